// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath/memory (slave).
// Memory handshake: mem_re/mem_we hold a request; the access completes on the rising edge
// where mem_ready=1 while the request is up, and the request stays asserted until then.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_re;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       reg_we;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       interrupt;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_re, mem_we, iord, ir_we, pc_we, pcsrc, alusrca, alusrcb, aluop,
               reg_we, regdst, memtoreg, interrupt, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_re, mem_we, iord, ir_we, pc_we, pcsrc, alusrca, alusrcb, aluop,
               reg_we, regdst, memtoreg, interrupt, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: registered state, control word decoded
// combinationally from state, opcode/funct, zero and mem_ready.
module mips_multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mips_multicycle_ctrl_if.master       bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_SYSCALL  = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_SYS   = 6'h0C;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t cur;
    state_t nxt;
    state_t dec_next;
    logic   legal;
    logic   is_rtype;

    assign is_rtype = (bus.opcode == OP_RTYPE);

    always_comb begin
        legal    = 1'b1;
        dec_next = S_FETCH;
        if (is_rtype) begin
            case (bus.funct)
                FN_ADD, FN_SUB, FN_SLT: dec_next = S_EXEC_R;
                FN_JR:                  dec_next = S_JUMP;
                FN_SYS:                 dec_next = S_SYSCALL;
                default:                legal    = 1'b0;
            endcase
        end else begin
            case (bus.opcode)
                OP_LW, OP_SW:     dec_next = S_MEM_ADDR;
                OP_ADDI, OP_XORI: dec_next = S_EXEC_I;
                OP_BEQ, OP_BNE:   dec_next = S_BRANCH;
                OP_J, OP_JAL:     dec_next = S_JUMP;
                default:          legal    = 1'b0;
            endcase
        end
        if (!legal) begin
            dec_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
            S_DECODE:   nxt = dec_next;
            S_EXEC_R:   nxt = S_WB_ALU;
            S_EXEC_I:   nxt = S_WB_ALU;
            S_WB_ALU:   nxt = S_FETCH;
            S_MEM_ADDR: nxt = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) nxt = S_MEM_WB;
            S_MEM_WB:   nxt = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) nxt = S_FETCH;
            S_BRANCH:   nxt = S_FETCH;
            S_JUMP:     nxt = S_FETCH;
            S_SYSCALL:  nxt = S_FETCH;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    // While rst_n is low only the fetch request is visible, so an aborted instruction
    // can never leave a partial register, PC or memory write behind.
    always_comb begin
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pcsrc     = 2'b00;
        bus.alusrca   = 1'b0;
        bus.alusrcb   = 2'b00;
        bus.aluop     = 2'b00;
        bus.reg_we    = 1'b0;
        bus.regdst    = 2'b00;
        bus.memtoreg  = 2'b00;
        bus.interrupt = 1'b0;
        bus.illegal   = 1'b0;
        if (!rst_n) begin
            bus.mem_re = 1'b1;
        end else begin
            case (cur)
                S_FETCH: begin
                    bus.mem_re  = 1'b1;
                    bus.alusrcb = 2'b01;
                    bus.ir_we   = bus.mem_ready;
                    bus.pc_we   = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alusrcb = 2'b11;
                    bus.illegal = ~legal;
                end
                S_EXEC_R: begin
                    bus.alusrca = 1'b1;
                    bus.aluop   = 2'b10;
                end
                S_EXEC_I: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    bus.aluop   = (bus.opcode == OP_XORI) ? 2'b11 : 2'b00;
                end
                S_WB_ALU: begin
                    bus.reg_we = 1'b1;
                    bus.regdst = is_rtype ? 2'b01 : 2'b00;
                end
                S_MEM_ADDR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                end
                S_MEM_RD: begin
                    bus.mem_re = 1'b1;
                    bus.iord   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_we   = 1'b1;
                    bus.memtoreg = 2'b01;
                end
                S_MEM_WR: begin
                    bus.mem_we = 1'b1;
                    bus.iord   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alusrca = 1'b1;
                    bus.aluop   = 2'b01;
                    bus.pcsrc   = 2'b01;
                    bus.pc_we   = ((bus.opcode == OP_BEQ) &  bus.zero) |
                                  ((bus.opcode == OP_BNE) & ~bus.zero);
                end
                S_JUMP: begin
                    bus.pc_we = 1'b1;
                    bus.pcsrc = is_rtype ? 2'b11 : 2'b10;
                    if (bus.opcode == OP_JAL) begin
                        bus.reg_we   = 1'b1;
                        bus.regdst   = 2'b10;
                        bus.memtoreg = 2'b10;
                    end
                end
                S_SYSCALL: bus.interrupt = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.state = cur;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle control-word vectors, hand-written
// wait/reset/halt sequences and a randomized instruction stream against an instruction-level model.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();
    mips_multicycle_ctrl_if bus_h ();

    mips_multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    mips_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

    assign bus_h.opcode    = bus.opcode;
    assign bus_h.funct     = bus.funct;
    assign bus_h.zero      = bus.zero;
    assign bus_h.mem_ready = bus.mem_ready;

    wire [18:0] act = {bus.mem_re, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pcsrc,
                       bus.alusrca, bus.alusrcb, bus.aluop, bus.reg_we, bus.regdst,
                       bus.memtoreg, bus.interrupt, bus.illegal};
    wire [18:0] act_h = {bus_h.mem_re, bus_h.mem_we, bus_h.iord, bus_h.ir_we, bus_h.pc_we,
                         bus_h.pcsrc, bus_h.alusrca, bus_h.alusrcb, bus_h.aluop, bus_h.reg_we,
                         bus_h.regdst, bus_h.memtoreg, bus_h.interrupt, bus_h.illegal};

    // Control word: re we iord ir_we pc_we pcsrc alusrca alusrcb aluop reg_we regdst memtoreg int ill
    function automatic logic [18:0] cw(input int re, we, io, irw, pcw, ps, asa, asb, op,
                                       input int rw, rd, mt, it, il);
        return {re[0], we[0], io[0], irw[0], pcw[0], ps[1:0], asa[0], asb[1:0], op[1:0],
                rw[0], rd[1:0], mt[1:0], it[0], il[0]};
    endfunction

    typedef struct packed {
        logic [5:0]       op;
        logic [5:0]       fn;
        logic             z;
        logic [2:0]       n;
        logic [4:0][18:0] cyc;
    } vec_t;

    function automatic vec_t mkv(input int op, fn, z, n,
                                 input logic [18:0] c0, c1, c2, c3, c4);
        vec_t v;
        v.op = op[5:0];
        v.fn = fn[5:0];
        v.z  = z[0];
        v.n  = n[2:0];
        v.cyc[0] = c0;
        v.cyc[1] = c1;
        v.cyc[2] = c2;
        v.cyc[3] = c3;
        v.cyc[4] = c4;
        return v;
    endfunction

    // Instruction-level reference: {done, cycles, #reg writes, regdst, memtoreg,
    // #extra pc writes, pcsrc, #interrupts, #illegal, #data accesses}.
    function automatic logic [24:0] model(input logic [5:0] op, fn, input logic z,
                                          input int wf, wd);
        int cyc;
        logic [1:0] rw, rd, mt, pcw, ps, it, il, dt;
        cyc = 0; rw = 0; rd = 0; mt = 0; pcw = 0; ps = 0; it = 0; il = 0; dt = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h22, 6'h2A: begin cyc = 4; rw = 1; rd = 1; end
                6'h08:               begin cyc = 3; pcw = 1; ps = 3; end
                6'h0C:               begin cyc = 3; it = 1; end
                default:             begin cyc = 2; il = 1; end
            endcase
        end else begin
            case (op)
                6'h23:        begin cyc = 5; rw = 1; mt = 1; dt = 1; end
                6'h2B:        begin cyc = 4; dt = 1; end
                6'h08, 6'h0E: begin cyc = 4; rw = 1; end
                6'h04:        begin cyc = 3; if (z)  begin pcw = 1; ps = 1; end end
                6'h05:        begin cyc = 3; if (!z) begin pcw = 1; ps = 1; end end
                6'h02:        begin cyc = 3; pcw = 1; ps = 2; end
                6'h03:        begin cyc = 3; pcw = 1; ps = 2; rw = 1; rd = 2; mt = 2; end
                default:      begin cyc = 2; il = 1; end
            endcase
        end
        cyc = cyc + wf + ((dt != 0) ? wd : 0);
        return {1'b1, cyc[7:0], rw, rd, mt, pcw, ps, it, il, dt};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at posedge+1 with opcode/funct/zero already driven; samples at negedge.
    task automatic cyc(input string name, input logic rdy, input logic [18:0] exp);
        bus.mem_ready = rdy;
        #4;
        chk(name, 32'(act), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
    endtask

    logic [18:0] w_rst, w_f, w_f0, w_d, w_di, w_xr, w_xa, w_xx, w_wr, w_wi, w_ma, w_mr;
    logic [18:0] w_mw, w_sw, w_bt, w_bn, w_jj, w_jal, w_jr, w_sy;
    vec_t        vecs[16];
    logic [5:0]  pool_op[16];
    logic [5:0]  pool_fn[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, bad, viol;
        w_rst = cw(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
        w_f   = cw(1,0,0,1,1,0,0,1,0,0,0,0,0,0);
        w_f0  = cw(1,0,0,0,0,0,0,1,0,0,0,0,0,0);
        w_d   = cw(0,0,0,0,0,0,0,3,0,0,0,0,0,0);
        w_di  = cw(0,0,0,0,0,0,0,3,0,0,0,0,0,1);
        w_xr  = cw(0,0,0,0,0,0,1,0,2,0,0,0,0,0);
        w_xa  = cw(0,0,0,0,0,0,1,2,0,0,0,0,0,0);
        w_xx  = cw(0,0,0,0,0,0,1,2,3,0,0,0,0,0);
        w_wr  = cw(0,0,0,0,0,0,0,0,0,1,1,0,0,0);
        w_wi  = cw(0,0,0,0,0,0,0,0,0,1,0,0,0,0);
        w_ma  = cw(0,0,0,0,0,0,1,2,0,0,0,0,0,0);
        w_mr  = cw(1,0,1,0,0,0,0,0,0,0,0,0,0,0);
        w_mw  = cw(0,0,0,0,0,0,0,0,0,1,0,1,0,0);
        w_sw  = cw(0,1,1,0,0,0,0,0,0,0,0,0,0,0);
        w_bt  = cw(0,0,0,0,1,1,1,0,1,0,0,0,0,0);
        w_bn  = cw(0,0,0,0,0,1,1,0,1,0,0,0,0,0);
        w_jj  = cw(0,0,0,0,1,2,0,0,0,0,0,0,0,0);
        w_jal = cw(0,0,0,0,1,2,0,0,0,1,2,2,0,0);
        w_jr  = cw(0,0,0,0,1,3,0,0,0,0,0,0,0,0);
        w_sy  = cw(0,0,0,0,0,0,0,0,0,0,0,0,1,0);

        vecs[0]  = mkv(6'h00, 6'h20, 0, 4, w_f, w_d, w_xr, w_wr, 19'd0);
        vecs[1]  = mkv(6'h00, 6'h22, 0, 4, w_f, w_d, w_xr, w_wr, 19'd0);
        vecs[2]  = mkv(6'h00, 6'h2A, 1, 4, w_f, w_d, w_xr, w_wr, 19'd0);
        vecs[3]  = mkv(6'h08, 6'h15, 0, 4, w_f, w_d, w_xa, w_wi, 19'd0);
        vecs[4]  = mkv(6'h0E, 6'h00, 0, 4, w_f, w_d, w_xx, w_wi, 19'd0);
        vecs[5]  = mkv(6'h23, 6'h20, 0, 5, w_f, w_d, w_ma, w_mr, w_mw);
        vecs[6]  = mkv(6'h2B, 6'h0C, 0, 4, w_f, w_d, w_ma, w_sw, 19'd0);
        vecs[7]  = mkv(6'h04, 6'h00, 1, 3, w_f, w_d, w_bt, 19'd0, 19'd0);
        vecs[8]  = mkv(6'h04, 6'h00, 0, 3, w_f, w_d, w_bn, 19'd0, 19'd0);
        vecs[9]  = mkv(6'h05, 6'h00, 1, 3, w_f, w_d, w_bn, 19'd0, 19'd0);
        vecs[10] = mkv(6'h05, 6'h00, 0, 3, w_f, w_d, w_bt, 19'd0, 19'd0);
        vecs[11] = mkv(6'h02, 6'h08, 0, 3, w_f, w_d, w_jj, 19'd0, 19'd0);
        vecs[12] = mkv(6'h03, 6'h00, 0, 3, w_f, w_d, w_jal, 19'd0, 19'd0);
        vecs[13] = mkv(6'h00, 6'h08, 0, 3, w_f, w_d, w_jr, 19'd0, 19'd0);
        vecs[14] = mkv(6'h00, 6'h0C, 0, 3, w_f, w_d, w_sy, 19'd0, 19'd0);
        vecs[15] = mkv(6'h3F, 6'h00, 0, 2, w_f, w_di, 19'd0, 19'd0, 19'd0);

        pool_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08,
                    6'h0E, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h01};
        pool_fn = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h0C, 6'h00, 6'h00, 6'h00,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21, 6'h00};

        // Reset: only the fetch request is visible, even with mem_ready high.
        set_ins(6'h00, 6'h20, 1'b0);
        bus.mem_ready = 1'b1;
        #3;
        chk("reset_word", 32'(act), 32'(w_rst));
        chk("reset_word_h", 32'(act_h), 32'(w_rst));
        @(posedge clk);
        #1;
        chk("reset_hold", 32'(act), 32'(w_rst));
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            set_ins(vecs[v].op, vecs[v].fn, vecs[v].z);
            for (int c = 0; c < int'(vecs[v].n); c++) begin
                cyc($sformatf("vec%0d_cyc%0d", v, c + 1), 1'b1, vecs[v].cyc[c]);
            end
        end
        cyc("illegal_refetch", 1'b1, w_f);
        cyc("illegal_again_decode", 1'b1, w_di);

        // lw with three MEM_RD wait cycles: eight cycles in total.
        set_ins(6'h23, 6'h00, 1'b0);
        cyc("lw_fetch", 1'b1, w_f);
        cyc("lw_decode", 1'b1, w_d);
        cyc("lw_addr", 1'b1, w_ma);
        cyc("lw_rd_wait1", 1'b0, w_mr);
        cyc("lw_rd_wait2", 1'b0, w_mr);
        cyc("lw_rd_wait3", 1'b0, w_mr);
        cyc("lw_rd_done", 1'b1, w_mr);
        cyc("lw_wb", 1'b1, w_mw);

        // sw with two fetch wait cycles and one write wait cycle.
        set_ins(6'h2B, 6'h00, 1'b0);
        cyc("sw_fetch_wait1", 1'b0, w_f0);
        cyc("sw_fetch_wait2", 1'b0, w_f0);
        cyc("sw_fetch", 1'b1, w_f);
        cyc("sw_decode", 1'b1, w_d);
        cyc("sw_addr", 1'b1, w_ma);
        cyc("sw_wr_wait", 1'b0, w_sw);
        cyc("sw_wr_done", 1'b1, w_sw);
        cyc("sw_next_fetch", 1'b1, w_f);
        cyc("sw_next_decode", 1'b1, w_d);
        cyc("sw_next_addr", 1'b1, w_ma);
        cyc("sw_next_wr", 1'b1, w_sw);

        // Twelve back-to-back syscalls: one pulse each, always in the third cycle.
        set_ins(6'h00, 6'h0C, 1'b0);
        cnt = 0;
        bad = 0;
        for (int c = 0; c < 36; c++) begin
            bus.mem_ready = 1'b1;
            #4;
            if (bus.interrupt) begin
                cnt++;
                if ((c % 3) != 2) bad++;
            end
            @(posedge clk);
            #1;
        end
        chk("syscall_pulses", 32'(cnt), 32'd12);
        chk("syscall_pulse_pos", 32'(bad), 32'd0);

        // Randomized instruction stream with a reactive memory.
        viol = 0;
        for (int k = 0; k < 200; k++) begin
            int p, wf, wd, wl, ncyc, nrw, npcw, nint, nill, ndata;
            logic [1:0] rd_s, mt_s, ps_s;
            logic fetched, rdy, z, done;
            logic [5:0] op, fn;
            logic [24:0] got_s;
            p    = $urandom_range(0, 15);
            op   = pool_op[p];
            fn   = (op == 6'h00) ? pool_fn[p] : 6'($urandom);
            z    = 1'($urandom_range(0, 1));
            wf   = $urandom_range(0, 3);
            wd   = $urandom_range(0, 3);
            wl   = wf;
            ncyc = 0; nrw = 0; npcw = 0; nint = 0; nill = 0; ndata = 0;
            rd_s = 0; mt_s = 0; ps_s = 0;
            fetched = 1'b0;
            done = 1'b0;
            set_ins(op, fn, z);
            for (int c = 0; c < 40; c++) begin
                if (fetched && bus.mem_re && !bus.iord) begin
                    done = 1'b1;
                    break;
                end
                if (bus.mem_re || bus.mem_we) begin
                    if (wl > 0) begin
                        rdy = 1'b0;
                        wl--;
                    end else begin
                        rdy = 1'b1;
                    end
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
                bus.mem_ready = rdy;
                #4;
                ncyc++;
                if (bus.mem_re && bus.mem_we) viol++;
                if (bus.ir_we) fetched = 1'b1;
                if (bus.pc_we && !bus.ir_we) begin
                    npcw++;
                    ps_s = bus.pcsrc;
                end
                if (bus.reg_we) begin
                    nrw++;
                    rd_s = bus.regdst;
                    mt_s = bus.memtoreg;
                end
                if (bus.interrupt) nint++;
                if (bus.illegal) nill++;
                if ((bus.mem_re || bus.mem_we) && rdy) begin
                    if (bus.iord) ndata++;
                    wl = wd;
                end
                @(posedge clk);
                #1;
            end
            got_s = {done, 8'(ncyc), 2'(nrw), rd_s, mt_s, 2'(npcw), ps_s, 2'(nint),
                     2'(nill), 2'(ndata)};
            chk($sformatf("rand%0d_op%h_fn%h_z%0d_wf%0d_wd%0d", k, op, fn, z, wf, wd),
                32'(got_s), 32'(model(op, fn, z, wf, wd)));
        end
        chk("re_we_exclusive", 32'(viol), 32'd0);

        // Reset asserted in EXEC_R: no WB_ALU, clean restart from FETCH.
        set_ins(6'h00, 6'h20, 1'b0);
        cyc("rstx_fetch", 1'b1, w_f);
        cyc("rstx_decode", 1'b1, w_d);
        bus.mem_ready = 1'b1;
        #1;
        chk("rstx_exec_r", 32'(act), 32'(w_xr));
        rst_n = 1'b0;
        #1;
        chk("rstx_abort", 32'(act), 32'(w_rst));
        @(posedge clk);
        #1;
        chk("rstx_abort_hold", 32'(act), 32'(w_rst));
        rst_n = 1'b1;
        cyc("rstx_post_fetch", 1'b1, w_f);
        cyc("rstx_post_decode", 1'b1, w_d);
        cyc("rstx_post_exec", 1'b1, w_xr);
        cyc("rstx_post_wb", 1'b1, w_wr);

        // Illegal opcode: ILLEGAL_HALT=1 parks in HALT, ILLEGAL_HALT=0 refetches.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ins(6'h3F, 6'h00, 1'b0);
        bus.mem_ready = 1'b1;
        #4;
        chk("halt_fetch_h", 32'(act_h), 32'(w_f));
        chk("halt_fetch", 32'(act), 32'(w_f));
        @(posedge clk);
        #1;
        #4;
        chk("halt_decode_h", 32'(act_h), 32'(w_di));
        chk("halt_decode", 32'(act), 32'(w_di));
        @(posedge clk);
        #1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            set_ins(6'h00, 6'h20, 1'b0);
            bus.mem_ready = 1'b1;
            #4;
            if (bus_h.illegal) cnt++;
            chk($sformatf("halt_idle%0d", c), 32'(act_h), 32'd0);
            if (c == 0) chk("noh_refetch", 32'(act), 32'(w_f));
            @(posedge clk);
            #1;
        end
        chk("halt_no_more_illegal", 32'(cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
